// File: rtl/ps2_pkg.sv
// ps2_pkg: state encoding, frame size and command constants shared by the PS/2 host blocks.
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, RELEASE} ps2_state_t;
    localparam int PS2_FRAME_BITS = 11;
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK = 8'hFA;
    // Start 0, data LSB first, odd parity, stop 1; bit 0 goes out first.
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchroniser for a PS/2 pad line plus falling-edge pulse.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic sync,
    output logic fall
);
    logic [2:0] sh;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sh <= 3'b111;
        else sh <= {sh[1:0], line};
    end
    assign sync = sh[1];
    // Falling edge when the synchronised history {previous, current} is 2'b10.
    assign fall = sh[2] & ~sh[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter using open-drain pull-low enables.
// Define PS2_TX_RETRY_EN to retransmit the latched byte once after a NACK or timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);
    localparam int CW = $clog2((TIMEOUT_CYCLES > INHIBIT_CYCLES ? TIMEOUT_CYCLES : INHIBIT_CYCLES) + 1);
    ps2_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0] nbit, nbit_n;
    logic [PS2_FRAME_BITS-1:0] frame, frame_n;
    logic nack, nack_n, done_n, err_n, can_retry;
    logic clk_s, clk_fall, data_s, data_fall_unused;
    logic watch, timeout, inhibit_last;

    ps2_sync_edge u_clk (.clk, .rst, .line(PS2_CLK), .sync(clk_s), .fall(clk_fall));
    ps2_sync_edge u_data (.clk, .rst, .line(PS2_DATA), .sync(data_s), .fall(data_fall_unused));

`ifdef PS2_TX_RETRY_EN
    logic retried;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) retried <= 1'b0;
        else if (state == IDLE) retried <= 1'b0;
        else if (state == RELEASE && state_n == INHIBIT) retried <= 1'b1;
    end
    assign can_retry = ~retried;
`else
    assign can_retry = 1'b0;
`endif

    assign inhibit_last = state == INHIBIT && cnt == CW'(INHIBIT_CYCLES - 1);
    assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
    assign watch = state inside {REQ, SHIFT, ACK, RELEASE};

    always_comb begin
        state_n = state;
        cnt_n = cnt + 1'b1;
        nbit_n = nbit;
        frame_n = frame;
        nack_n = nack;
        done_n = 1'b0;
        err_n = 1'b0;
        if (watch && clk_fall) cnt_n = '0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (tx_valid) begin
                    state_n = INHIBIT;
                    frame_n = ps2_frame(tx_data);
                    nack_n = 1'b0;
                end
            end
            INHIBIT: if (inhibit_last) begin
                state_n = REQ;
                cnt_n = '0;
                nbit_n = '0;
            end
            REQ: if (clk_fall) begin
                state_n = SHIFT;
                nbit_n = 4'd1;
            end
            SHIFT: if (clk_fall) begin
                nbit_n = nbit + 4'd1;
                if (nbit == 4'd9) state_n = ACK;
            end
            ACK: if (clk_fall) begin
                state_n = RELEASE;
                nack_n = data_s;
            end
            RELEASE: if (clk_s && data_s) begin
                if (!nack) begin
                    state_n = IDLE;
                    done_n = 1'b1;
                end else if (can_retry) begin
                    state_n = INHIBIT;
                    cnt_n = '0;
                    nack_n = 1'b0;
                end else begin
                    state_n = IDLE;
                    err_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // A stalled device releases the bus; a retry still waits for release first.
        if (watch && timeout && !clk_fall && state_n == state) begin
            if (can_retry && state != RELEASE) begin
                state_n = RELEASE;
                nack_n = 1'b1;
                cnt_n = '0;
            end else begin
                state_n = IDLE;
                err_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            nbit <= '0;
            frame <= '0;
            nack <= 1'b0;
            tx_done <= 1'b0;
            tx_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            nbit <= nbit_n;
            frame <= frame_n;
            nack <= nack_n;
            tx_done <= done_n;
            tx_err <= err_n;
        end
    end

    assign tx_ready = state == IDLE;
    assign tx_busy = ~tx_ready;
    assign ps2_clk_oe = state == INHIBIT;
    assign ps2_data_oe = inhibit_last || state == REQ || (state == SHIFT && !frame[nbit]);
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized scoreboard bench with a behavioural PS/2 keyboard model on wired-AND pads.
module tb_ps2_host_tx;
    localparam int INHIB = 40;
    localparam int TMO = 1500;
    localparam int H = 20;
    localparam int M_ACK = 0, M_NACK = 1, M_SILENT = 2, M_RST = 3;

    typedef struct {
        logic [7:0] data;
        bit done;
        bit frame;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1;
    logic dev_clk = 1'b1, dev_data = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic tx_valid = 1'b0;
    logic tx_ready, ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err;
    logic pad_clk, pad_data;
    exp_t exp_q[$];
    logic [10:0] cap_q[$];
    exp_t mon_e;
    int passed = 0, total = 0, frames = 0, pulses = 0;

    assign pad_clk = dev_clk & ~ps2_clk_oe;
    assign pad_data = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INHIB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .PS2_CLK(pad_clk), .PS2_DATA(pad_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .tx_busy(tx_busy),
        .tx_done(tx_done), .tx_err(tx_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Frame as the keyboard sees it: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        int ones;
        ones = $countones(b);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
    endfunction

    always @(posedge ps2_clk_oe) frames++;

    always @(negedge clk) begin
        if (tx_done || tx_err) begin
            pulses++;
            if (exp_q.size() == 0) chk("unexpected pulse {done,err}", {30'd0, tx_done, tx_err}, 0);
            else begin
                mon_e = exp_q.pop_front();
                chk("result {done,err}", {30'd0, tx_done, tx_err}, mon_e.done ? 2 : 1);
                if (mon_e.frame) begin
                    if (cap_q.size() == 0) chk("frame captured", cap_q.size(), 1);
                    else chk("frame bits", cap_q.pop_front(), model_frame(mon_e.data));
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data = b;
        tx_valid = 1'b1;
        chk("ready at accept", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("clk_oe after accept", ps2_clk_oe, 1);
        chk("busy after accept", tx_busy, 1);
    endtask

    task automatic device(input int mode);
        int n, inh, marks;
        logic [10:0] cap;
        n = 0;
        inh = 0;
        marks = 0;
        cap = '0;
        while (pad_clk && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("inhibit seen", pad_clk, 0);
        n = 0;
        while (!pad_clk && n < INHIB + 20) begin
            inh++;
            if (!pad_data) marks++;
            @(negedge clk);
            n++;
        end
        chk("inhibit length", inh, INHIB);
        chk("start marks in inhibit", marks, 1);
        chk("start bit in request", pad_data, 0);
        if (!pad_clk || mode == M_SILENT) return;
        cap[0] = pad_data;
        repeat (H) @(negedge clk);
        for (int i = 1; i <= 11; i++) begin
            dev_clk = 1'b0;
            if (mode == M_RST && i == 5) return;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            if (i <= 10) cap[i] = pad_data;
            if (i == 10) begin
                cap_q.push_back(cap);
                dev_data = (mode == M_NACK);
            end
            repeat (H) @(negedge clk);
        end
        dev_data = 1'b1;
    endtask

    task automatic xact(input logic [7:0] b, input int mode);
        exp_t e;
        int n;
        e.data = b;
        e.done = (mode == M_ACK);
        e.frame = (mode != M_SILENT);
        exp_q.push_back(e);
        fork
            send(b);
            device(mode);
        join
        n = 0;
        while (!(tx_done || tx_err) && n < 3 * TMO) begin
            @(negedge clk);
            n++;
        end
        if (mode == M_SILENT) begin
            chk("timeout latency", n, TMO);
            chk("clk_oe after timeout", ps2_clk_oe, 0);
            chk("data_oe after timeout", ps2_data_oe, 0);
        end
        @(negedge clk);
        chk("completion", exp_q.size(), 0);
        exp_q.delete();
        chk("ready after frame", tx_ready, 1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f, p;
        logic [7:0] b;
        repeat (3) @(negedge clk);
        chk("reset tx_ready", tx_ready, 1);
        chk("reset tx_busy", tx_busy, 0);
        chk("reset clk_oe", ps2_clk_oe, 0);
        chk("reset data_oe", ps2_data_oe, 0);
        chk("reset tx_done", tx_done, 0);
        chk("reset tx_err", tx_err, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle ready", tx_ready, 1);
        xact(8'hED, M_ACK);
        xact(8'hF4, M_ACK);
        xact(8'hFF, M_NACK);
        xact(8'hFF, M_SILENT);
        f = frames;
        fork
            send(8'hED);
            device(M_RST);
        join
        repeat (4) @(negedge clk);
        chk("data_oe before reset", ps2_data_oe, 1);
        p = pulses;
        #2 rst = 1'b1;
        #1;
        chk("clk_oe in reset", ps2_clk_oe, 0);
        chk("data_oe in reset", ps2_data_oe, 0);
        chk("ready in reset", tx_ready, 1);
        dev_clk = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * INHIB) @(negedge clk);
        chk("pulses after reset", pulses - p, 0);
        chk("ready after reset", tx_ready, 1);
        chk("frames after reset", frames - f, 1);
        f = frames;
        fork
            xact(8'h5A, M_ACK);
            begin
                repeat (INHIB + 100) @(negedge clk);
                chk("busy at extra valid", tx_busy, 1);
                tx_data = 8'hFF;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        repeat (INHIB + 20) @(negedge clk);
        chk("frames for busy request", frames - f, 1);
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            xact(b, ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK);
        end
        chk("capture queue drained", cap_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
